// File: rtl/picobus_reg_bank.sv
// PicoBus slave: mode registers, write counter, push/pop FIFO window and status register.
// Read data is registered and forced to 0 whenever this slave is not addressed.
module picobus_reg_bank #(
  parameter logic [31:0]  BASE_ADDR  = 32'h0,
  parameter int unsigned  NUM_REGS   = 4,
  parameter logic [127:0] REG_MODES  = '0,
  parameter logic [31:0]  INIT_VAL   = 32'h0,
  parameter int unsigned  FIFO_DEPTH = 16
) (
  input  logic        PicoClk,
  input  logic        PicoRst_n,
  input  logic [31:0] PicoAddr,
  input  logic [31:0] PicoDataIn,
  input  logic        PicoRd,
  input  logic        PicoWr,
  output logic [31:0] PicoDataOut
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [29:0] WrcntIdx  = 30'(NUM_REGS);
  localparam logic [29:0] FifoIdx   = 30'(NUM_REGS + 1);
  localparam logic [29:0] StatusIdx = 30'(NUM_REGS + 2);
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

  // Address decode: subtraction wraps, so addresses below BASE_ADDR land far out of window.
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic        hit, wr_hit, rd_hit;

  assign offset   = PicoAddr - BASE_ADDR;
  assign word_idx = offset[31:2];
  assign hit      = (offset[1:0] == 2'b00) && (word_idx <= StatusIdx);
  assign wr_hit   = PicoWr && hit;
  assign rd_hit   = PicoRd && hit;

  logic [31:0]   regs_q [NUM_REGS];
  logic [31:0]   regs_d [NUM_REGS];
  logic [31:0]   wrcnt_q, wrcnt_d;
  logic [31:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]   rdata_q, rdata_d;

  logic        fifo_wr, fifo_rd, status_rd;
  logic        empty, full, push, pop;
  logic [31:0] status_word;

  assign fifo_wr   = wr_hit && (word_idx == FifoIdx);
  assign fifo_rd   = rd_hit && (word_idx == FifoIdx);
  assign status_rd = rd_hit && (word_idx == StatusIdx);
  assign empty     = (count_q == '0);
  assign full      = (count_q == FullCnt);
  assign pop       = fifo_rd && !empty;
  // A simultaneous pop frees a slot, so a push to a full FIFO still lands.
  assign push      = fifo_wr && (!full || pop);

  assign status_word = {12'h000, unf_q, ovf_q, full, empty, 16'(count_q)};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit && (word_idx == 30'(i))) begin
        unique case (REG_MODES[2*i +: 2])
          2'd0:    regs_d[i] = PicoDataIn;
          2'd1:    regs_d[i] = ~PicoDataIn;
          2'd2:    regs_d[i] = regs_q[i] ^ PicoDataIn;
          default: regs_d[i] = regs_q[i] + PicoDataIn;
        endcase
      end
    end
  end

  always_comb begin
    wrcnt_d = wrcnt_q;
    if (wr_hit) begin
      wrcnt_d = (word_idx == WrcntIdx) ? 32'd0 : wrcnt_q + 32'd1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // A set event in the same cycle as a STATUS read keeps the flag.
    ovf_d    = (fifo_wr && full && !pop) || (ovf_q && !status_rd);
    unf_d    = (fifo_rd && empty) || (unf_q && !status_rd);
  end

  always_comb begin
    rdata_d = 32'd0;
    if (rd_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (word_idx == 30'(i)) rdata_d = regs_q[i];
      end
      if (word_idx == WrcntIdx) rdata_d = wrcnt_q;
      if (pop)                  rdata_d = fifo_mem_q[rd_ptr_q];
      if (status_rd)            rdata_d = status_word;
    end
  end

  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= INIT_VAL;
      wrcnt_q  <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wrcnt_q  <= wrcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge PicoClk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= PicoDataIn;
  end

  assign PicoDataOut = rdata_q;

endmodule
